pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_stage.sv | 27 ++
 rtl/pipelined_adder.sv | 56 +++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and the per-stage payload carried down the adder pipeline.
package adder_pkg;
   localparam int DEFAULT_WIDTH  = 64;
   localparam int DEFAULT_STAGES = 4;
   localparam int MAX_WIDTH      = 256;
   typedef struct packed {
      logic                 valid;
      logic                 carry;
      logic [MAX_WIDTH-1:0] sum;
      logic [MAX_WIDTH-1:0] a;
      logic [MAX_WIDTH-1:0] b;
   } stage_t;
endpackage

// File: rtl/adder_stage.sv
// adder_stage: adds segment K of the operands plus the incoming carry and registers the payload.
module adder_stage
   import adder_pkg::*;
#(
   parameter int SEG = 16,
   parameter int K   = 0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_en,
   input  stage_t i_pay,
   output stage_t o_pay
);
   logic [SEG:0] w_seg;
   stage_t       w_next;
   stage_t       r_pay;
   always_comb begin
      w_seg  = {1'b0, i_pay.a[K*SEG +: SEG]} + {1'b0, i_pay.b[K*SEG +: SEG]} + {{SEG{1'b0}}, i_pay.carry};
      w_next = i_pay;
      w_next.sum[K*SEG +: SEG] = w_seg[SEG-1:0];
      w_next.carry = w_seg[SEG];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_pay <= '0;
      else if (i_en) r_pay <= w_next;
   assign o_pay = r_pay;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep segmented adder with valid/ready flow control and a global advance enable.
// Defining PIPELINED_ADDER_SUB_EN adds a SUB input selecting A - B (A + ~B + 1).
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             SUB,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   SUM
);
   localparam int SEG = WIDTH / STAGES;
   stage_t w_pay [STAGES+1];
   stage_t w_in;
   logic   w_en;
   logic   w_sub;
   logic   w_unused;
`ifdef PIPELINED_ADDER_SUB_EN
   assign w_sub = SUB;
`else
   assign w_sub = 1'b0;
`endif
   // Subtraction reuses the add path: invert B and inject the +1 as stage-0 carry-in.
   always_comb begin
      w_in = '0;
      w_in.valid = in_valid;
      w_in.carry = w_sub;
      w_in.a[WIDTH-1:0] = A;
      w_in.b[WIDTH-1:0] = w_sub ? ~B : B;
   end
   assign w_pay[0] = w_in;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_stage #(.SEG(SEG), .K(k)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (w_en),
         .i_pay (w_pay[k]),
         .o_pay (w_pay[k+1])
      );
   end
   assign w_en      = !out_valid || out_ready;
   assign in_ready  = w_en;
   assign out_valid = w_pay[STAGES].valid;
   assign SUM       = {w_pay[STAGES].carry, w_pay[STAGES].sum[WIDTH-1:0]};
   assign w_unused  = ^{w_pay[STAGES].a, w_pay[STAGES].b, w_pay[STAGES].sum};
endmodule
